result_reader: RTL and testbench

//  Read-back engine for the three result SRAM banks (a/b/c) filled by the TPU write-out path.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/row_serializer.sv | 45 ++++
 rtl/result_reader.sv | 161 ++++++++++++++++
 tb/tb_result_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result read-back path.
// Contents: default geometry constants (row width, beats per row), result bank
// codes and the result_reader state encoding.
package tpu_pkg;

  localparam int unsigned ARRAY_SIZE_DEF        = 32;
  localparam int unsigned OUTPUT_DATA_WIDTH_DEF = 16;
  localparam int unsigned BEAT_WIDTH_DEF        = 64;
  localparam int unsigned ROW_WIDTH             = ARRAY_SIZE_DEF * OUTPUT_DATA_WIDTH_DEF;
  localparam int unsigned BEATS                 = ROW_WIDTH / BEAT_WIDTH_DEF;

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;
  localparam logic [1:0] BANK_C = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_STREAM,
    ST_DONE
  } rr_state_e;

endpackage

// File: rtl/row_serializer.sv
// Holds one captured result row and presents it as a sequence of beats.
// Ports:
//   clk, srstn   clock / async active-low reset
//   load_i       capture row_i into the row buffer, restart at beat 0
//   row_i        full result row
//   advance_i    current beat accepted, move to the next one
//   beat_o       current beat (beat 0 = row LSBs)
//   row_last_o   current beat is the last one of the row
module row_serializer #(
  parameter int unsigned ROW_W  = 512,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              load_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic              advance_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic              row_last_o
);

  localparam int unsigned NB = ROW_W / BEAT_W;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [ROW_W-1:0]            row_buf_q;
  logic [CW-1:0]               beat_cnt_q;
  logic [NB-1:0][BEAT_W-1:0]   beats_w;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      row_buf_q  <= '0;
      beat_cnt_q <= '0;
    end else if (load_i) begin
      row_buf_q  <= row_i;
      beat_cnt_q <= '0;
    end else if (advance_i) begin
      beat_cnt_q <= row_last_o ? '0 : beat_cnt_q + CW'(1);
    end
  end

  assign beats_w    = row_buf_q;
  assign beat_o     = beats_w[beat_cnt_q];
  assign row_last_o = (beat_cnt_q == CW'(NB - 1));

endmodule

// File: rtl/result_reader.sv
// Read-back engine for the result SRAM banks a/b/c. Reads a host-programmed
// run of rows from one bank and streams each row as valid/ready beats.
// Ports:
//   clk, srstn                 clock / async active-low reset
//   rd_start/bank/base/rows    start request and its parameters (sampled in IDLE)
//   sram_re_x, sram_raddr_x    read port of bank x (x = a/b/c)
//   sram_rdata_x               read data of bank x, valid one cycle after re
//   m_valid/ready/data         beat stream toward the host
//   m_row_last, m_last         last beat of row / of whole transfer
//   rd_busy, rd_done, rd_err   status: busy, completion pulse, rejected-start pulse
module result_reader
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE        = 32,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned BEAT_WIDTH        = 64,
  parameter int unsigned ADDR_WIDTH        = 6
) (
  input  logic                                    clk,
  input  logic                                    srstn,
  input  logic                                    rd_start,
  input  logic [1:0]                              rd_bank,
  input  logic [ADDR_WIDTH-1:0]                   rd_base,
  input  logic [ADDR_WIDTH:0]                     rd_rows,
  output logic                                    sram_re_a,
  output logic                                    sram_re_b,
  output logic                                    sram_re_c,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_a,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_b,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [BEAT_WIDTH-1:0]                   m_data,
  output logic                                    m_row_last,
  output logic                                    m_last,
  output logic                                    rd_busy,
  output logic                                    rd_done,
  output logic                                    rd_err
);

  localparam int unsigned ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] ROWS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  rr_state_e             state_q, state_d;
  logic [1:0]            bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic [ADDR_WIDTH:0]   row_cnt_q, row_cnt_d;
  logic                  err_q, err_d;

  logic                  issue, streaming, last_row, row_last, advance;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ROW_W-1:0]      rdata_sel;
  logic [BEAT_WIDTH-1:0] beat;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      base_q    <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      base_q    <= base_d;
      rows_q    <= rows_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    base_d    = base_q;
    rows_d    = rows_q;
    row_cnt_d = row_cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (rd_bank != 2'd3 && rd_rows != '0 && rd_rows <= ROWS_MAX) begin
            bank_d    = rd_bank;
            base_d    = rd_base;
            rows_d    = rd_rows;
            row_cnt_d = '0;
            state_d   = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_STREAM;
      ST_STREAM: begin
        if (m_ready && row_last) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign issue     = (state_q == ST_ISSUE);
  assign streaming = (state_q == ST_STREAM);
  assign last_row  = (row_cnt_q == rows_q - 1'b1);
  // Address adds in ADDR_WIDTH bits so a run past the top row wraps to row 0.
  assign raddr     = base_q + row_cnt_q[ADDR_WIDTH-1:0];

  assign sram_re_a    = issue && (bank_q == BANK_A);
  assign sram_re_b    = issue && (bank_q == BANK_B);
  assign sram_re_c    = issue && (bank_q == BANK_C);
  assign sram_raddr_a = sram_re_a ? raddr : '0;
  assign sram_raddr_b = sram_re_b ? raddr : '0;
  assign sram_raddr_c = sram_re_c ? raddr : '0;

  always_comb begin
    rdata_sel = '0;
    unique case (bank_q)
      BANK_A:  rdata_sel = sram_rdata_a;
      BANK_B:  rdata_sel = sram_rdata_b;
      BANK_C:  rdata_sel = sram_rdata_c;
      default: rdata_sel = '0;
    endcase
  end

  assign advance = streaming && m_ready;

  row_serializer #(
    .ROW_W  (ROW_W),
    .BEAT_W (BEAT_WIDTH)
  ) u_ser (
    .clk        (clk),
    .srstn      (srstn),
    .load_i     (state_q == ST_CAPTURE),
    .row_i      (rdata_sel),
    .advance_i  (advance),
    .beat_o     (beat),
    .row_last_o (row_last)
  );

  assign m_valid    = streaming;
  assign m_data     = streaming ? beat : '0;
  assign m_row_last = streaming && row_last;
  assign m_last     = streaming && row_last && last_row;
  assign rd_busy    = (state_q != ST_IDLE);
  assign rd_done    = (state_q == ST_DONE);
  assign rd_err     = err_q;

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  localparam int ROW_W = 512;
  localparam int BW    = 64;
  localparam int NBEAT = ROW_W / BW;

  logic            clk = 1'b0;
  logic            srstn;
  logic            rd_start;
  logic [1:0]      rd_bank;
  logic [5:0]      rd_base;
  logic [6:0]      rd_rows;
  logic            sram_re_a, sram_re_b, sram_re_c;
  logic [5:0]      sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [ROW_W-1:0] sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic            m_valid, m_ready, m_row_last, m_last;
  logic [BW-1:0]   m_data;
  logic            rd_busy, rd_done, rd_err;

  int checks = 0;
  int errors = 0;

  logic [ROW_W-1:0] mem [0:2][0:63];
  logic [7:0]       relog[$];

  always #5 clk = ~clk;

  result_reader #(
    .ARRAY_SIZE        (32),
    .OUTPUT_DATA_WIDTH (16),
    .BEAT_WIDTH        (64),
    .ADDR_WIDTH        (6)
  ) dut (
    .clk          (clk),
    .srstn        (srstn),
    .rd_start     (rd_start),
    .rd_bank      (rd_bank),
    .rd_base      (rd_base),
    .rd_rows      (rd_rows),
    .sram_re_a    (sram_re_a),
    .sram_re_b    (sram_re_b),
    .sram_re_c    (sram_re_c),
    .sram_raddr_a (sram_raddr_a),
    .sram_raddr_b (sram_raddr_b),
    .sram_raddr_c (sram_raddr_c),
    .sram_rdata_a (sram_rdata_a),
    .sram_rdata_b (sram_rdata_b),
    .sram_rdata_c (sram_rdata_c),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_row_last   (m_row_last),
    .m_last       (m_last),
    .rd_busy      (rd_busy),
    .rd_done      (rd_done),
    .rd_err       (rd_err)
  );

  // Synchronous-read SRAM banks; every read strobe is logged as {bank, addr}.
  always @(posedge clk) begin
    if (sram_re_a) begin
      sram_rdata_a <= mem[0][sram_raddr_a];
      relog.push_back({2'd0, sram_raddr_a});
    end
    if (sram_re_b) begin
      sram_rdata_b <= mem[1][sram_raddr_b];
      relog.push_back({2'd1, sram_raddr_b});
    end
    if (sram_re_c) begin
      sram_rdata_c <= mem[2][sram_raddr_c];
      relog.push_back({2'd2, sram_raddr_c});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input logic [1:0] bank, input logic [5:0] base, input logic [6:0] rows,
                          input int unsigned ready_pct, input int restart_at, input int reset_at_hs);
    logic [BW-1:0] exp_data[$];
    logic          exp_rl[$];
    logic          exp_l[$];
    logic [ROW_W-1:0] row;
    logic [BW-1:0] prev_data;
    logic          prev_rl, prev_l, stalled;
    int cyc, hs, first_valid, done_cyc;
    for (int r = 0; r < int'(rows); r++) begin
      row = mem[bank][(int'(base) + r) % 64];
      for (int b = 0; b < NBEAT; b++) begin
        exp_data.push_back(row[b*BW +: BW]);
        exp_rl.push_back(b == NBEAT - 1);
        exp_l.push_back((b == NBEAT - 1) && (r == int'(rows) - 1));
      end
    end
    relog.delete();
    @(negedge clk);
    rd_bank = bank; rd_base = base; rd_rows = rows; rd_start = 1'b1;
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    rd_bank = 2'($urandom); rd_base = 6'($urandom); rd_rows = 7'($urandom);
    cyc = 0; hs = 0; first_valid = -1; done_cyc = -1; stalled = 1'b0;
    prev_data = '0; prev_rl = 1'b0; prev_l = 1'b0;
    while (done_cyc < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      rd_start = (cyc == restart_at);
      m_ready  = ($urandom_range(99) < ready_pct);
      if (reset_at_hs >= 0 && hs == reset_at_hs && m_valid) begin
        srstn = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", {m_row_last, m_last}, 0);
        check("rst_sram_re", {sram_re_a, sram_re_b, sram_re_c}, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_done_err", {rd_done, rd_err}, 0);
        @(negedge clk);
        check("rst_hold_done", rd_done, 0);
        srstn = 1'b1;
        rd_start = 1'b0;
        return;
      end
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_flags", {m_row_last, m_last}, {prev_rl, prev_l});
      end
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (m_ready) begin
          if (exp_data.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            check("beat_data", m_data, exp_data.pop_front());
            check("beat_row_last", m_row_last, exp_rl.pop_front());
            check("beat_last", m_last, exp_l.pop_front());
          end
          hs++;
        end
      end
      stalled = m_valid && !m_ready;
      prev_data = m_data; prev_rl = m_row_last; prev_l = m_last;
      check("no_err_busy", rd_err, 0);
      check("busy", rd_busy, 1);
      if (rd_done) begin
        done_cyc = cyc;
        check("done_no_valid", m_valid, 0);
      end
    end
    rd_start = 1'b0;
    check("done_seen", done_cyc >= 0, 1);
    check("first_valid_cycle", first_valid, 3);
    check("handshakes", hs, int'(rows) * NBEAT);
    if (ready_pct == 100) check("done_cycle", done_cyc, int'(rows) * (NBEAT + 2) + 1);
    @(negedge clk);
    check("single_done", rd_done, 0);
    check("idle_busy", rd_busy, 0);
    check("read_count", relog.size(), rows);
    for (int r = 0; r < int'(rows) && r < relog.size(); r++)
      check("read_addr", relog[r], {bank, 6'((int'(base) + r) % 64)});
  endtask

  task automatic bad_start(input logic [1:0] bank, input logic [6:0] rows);
    relog.delete();
    @(negedge clk);
    rd_bank = bank; rd_base = 6'($urandom); rd_rows = rows; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("err_pulse", rd_err, 1);
    check("err_busy", rd_busy, 0);
    @(negedge clk);
    check("err_clear", rd_err, 0);
    check("err_busy2", rd_busy, 0);
    check("err_no_read", relog.size(), 0);
  endtask

  initial begin
    srstn = 1'b0; rd_start = 1'b0; rd_bank = '0; rd_base = '0; rd_rows = '0; m_ready = 1'b0;
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 64; r++)
        for (int w = 0; w < ROW_W / 32; w++)
          mem[b][r][w*32 +: 32] = $urandom;
    repeat (2) @(negedge clk);
    check("reset_outputs", {m_valid, m_row_last, m_last, rd_busy, rd_done, rd_err}, 0);
    check("reset_re", {sram_re_a, sram_re_b, sram_re_c}, 0);
    check("reset_data", m_data, 0);
    srstn = 1'b1;
    @(negedge clk);

    run_xfer(2'd0, 6'd0, 7'd1, 100, -1, -1);
    run_xfer(2'd2, 6'd62, 7'd4, 100, -1, -1);
    run_xfer(2'd1, 6'($urandom), 7'd3, 50, -1, -1);
    for (int i = 0; i < 3; i++)
      run_xfer(2'($urandom_range(2)), 6'($urandom), 7'($urandom_range(1, 5)), 70, -1, -1);
    run_xfer(2'd0, 6'd17, 7'd64, 100, -1, -1);

    bad_start(2'd0, 7'd0);
    bad_start(2'd0, 7'd65);
    bad_start(2'd3, 7'd2);

    run_xfer(2'd1, 6'd10, 7'd2, 100, 7, -1);

    run_xfer(2'd0, 6'd5, 7'd3, 100, -1, NBEAT + 3);
    run_xfer(2'd2, 6'd30, 7'd2, 100, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
